// File: rtl/ysyx_23060187_lsu_pkg.sv
// ============================================================================
// Module      : ysyx_23060187_lsu_pkg
// Description : Shared encodings for the load/store unit and its lane aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_23060187_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_X = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef logic [1:0] state_t;

    // An access that cannot be issued: illegal size or not naturally aligned.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060187_lsu_align.sv
// ============================================================================
// Module      : ysyx_23060187_lsu_align
// Description : Byte-lane mask / store replication and load extract / extend.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060187_lsu_align
    import ysyx_23060187_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = rdata[7:0];
        case (off)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
    end

    // Halves are only ever taken from an even offset.
    assign rd_half = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wmask       = 4'b0000;
        wdata_lanes = 32'd0;
        rdata_ext   = 32'd0;
        case (size)
            SZ_B: begin
                wmask       = 4'b0001 << off;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            SZ_H: begin
                wmask       = 4'b0011 << off;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            SZ_W: begin
                wmask       = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = rdata;
            end
            default: begin
                wmask       = 4'b0000;
                wdata_lanes = 32'd0;
                rdata_ext   = 32'd0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060187_lsu.sv
// ============================================================================
// Module      : ysyx_23060187_lsu
// Description : Multi-cycle load/store unit with a req/gnt/rvalid memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060187_lsu
    import ysyx_23060187_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state;
    logic             wen;
    logic [1:0]       size;
    logic             is_unsigned;
    logic [1:0]       off;
    logic [CNT_W-1:0] cnt;

    logic [1:0]  al_size;
    logic [1:0]  al_off;
    logic        al_unsigned;
    logic [3:0]  lane_wmask;
    logic [31:0] lane_wdata;
    logic [31:0] load_ext;
    logic        req_bad;
    logic        timeout_hit;

    assign req_ready = (state == ST_IDLE);
    assign req_bad   = access_bad(req_size, req_addr[1:0]);

    // The cnt-th REQ/WAIT cycle is the last one allowed; a gnt/rvalid there loses.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    // One aligner serves both directions: incoming request in IDLE, latched access after.
    assign al_size     = req_ready ? req_size       : size;
    assign al_off      = req_ready ? req_addr[1:0]  : off;
    assign al_unsigned = req_ready ? req_unsigned   : is_unsigned;

    ysyx_23060187_lsu_align u_align (
        .size        (al_size),
        .off         (al_off),
        .is_unsigned (al_unsigned),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .wmask       (lane_wmask),
        .wdata_lanes (lane_wdata),
        .rdata_ext   (load_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wen         <= 1'b0;
            size        <= SZ_B;
            is_unsigned <= 1'b0;
            off         <= 2'b00;
            cnt         <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            resp_err    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wmask   <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt        <= '0;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    if (req_valid) begin
                        wen         <= req_wen;
                        size        <= req_size;
                        is_unsigned <= req_unsigned;
                        off         <= req_addr[1:0];
                        if (req_bad) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_wen;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_wen ? lane_wdata : 32'd0;
                            mem_wmask <= req_wen ? lane_wmask : 4'b0000;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (timeout_hit || mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        mem_wmask <= 4'b0000;
                    end
                    if (timeout_hit) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else if (mem_gnt) begin
                        if (wen) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (timeout_hit) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else if (mem_rvalid) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_ext;
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ysyx_23060187_lsu.md
Name: ysyx_23060187_lsu

Overview:
Multi-cycle load/store unit downstream of the core's execute datapath, replacing the direct combinational data_ram hookup. It accepts one byte/half/word access per handshake from the core. It drives a word-aligned request/grant/rvalid memory port with a byte-lane mask. It returns sign/zero-extended load data or an error to the core.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before aborting with error; 0 disables the timeout.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  1  core access request
req_ready  out  1  LSU can accept a request
req_wen  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  loads: zero-extend (lbu/lhu) when 1
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal size or timeout; valid with resp_valid
mem_req  out  1  memory request
mem_gnt  in  1  memory accepts request
mem_we  out  1  write enable
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_wdata  out  32  store data replicated to lanes
mem_wmask  out  4  byte-lane enables
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset gives IDLE; req_ready=1, every other output 0, timeout counter 0.
- Outputs are registered, except req_ready, which equals (state==IDLE).
- IDLE: on req_valid, latch wen, size, unsigned, addr and wdata.
  - If size==3, or size==1 with addr[0]!=0, or size==2 with addr[1:0]!=0: go to RESP with err=1. No mem_req is issued.
  - Otherwise go to REQ.
- REQ: mem_req=1, and mem_we/addr/wdata/wmask stay stable until mem_gnt.
  - On gnt with a store: go to RESP with err=0.
  - On gnt with a load: go to WAIT.
  - mem_req drops the cycle after gnt.
- WAIT: on mem_rvalid, capture the formatted data and go to RESP. mem_rvalid is ignored in every other state.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err return to 0 in IDLE.
- Minimum latency, acceptance to resp_valid:
  - store with same-cycle gnt: 2 cycles.
  - load with gnt, then rvalid next cycle: 3 cycles.
- Write lanes, with off = addr[1:0]:
  - byte: wmask = 1<<off, wdata = {4{wdata[7:0]}}.
  - half: wmask = 3<<off, wdata = {2{wdata[15:0]}}.
  - word: wmask = 4'hF, wdata = wdata.
  - mem_wmask = 0 for loads.
- Read extract:
  - byte = rdata[8*off+:8]; half = rdata[8*off+:16].
  - Sign-extend unless unsigned. Word ignores unsigned.
- Timeout: the counter increments each cycle in REQ or WAIT and clears in IDLE.
  - When it reaches TIMEOUT, go to RESP with err=1 and drop mem_req.
  - A gnt or rvalid arriving in that same cycle is ignored.
- A new req_valid during REQ/WAIT/RESP is not accepted (ready=0). The core must hold the request.
- Reset asserted mid-transaction immediately returns to IDLE with all outputs cleared. The outstanding memory read is abandoned.

Decomposition:
- Shared package ysyx_23060187_lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W;
  - the state enum (IDLE/REQ/WAIT/RESP).
- One combinational sub-module, ysyx_23060187_lsu_align, contains the lane-mask/replication and load-extract/extend logic. It is shared by both directions and unit-testable on its own.

Test Plan:
- lb at addr 0x8000_0003; mem_rdata=0x80AB_CDEF; gnt immediate, rvalid next cycle → resp_rdata=0xFFFF_FF80, err=0, resp_valid 3 cycles after acceptance.
- lhu at 0x8000_0002, mem_rdata=0x9234_5678 → resp_rdata=0x0000_9234; lh with the same inputs → 0xFFFF_9234.
- sb of wdata=0x0000_00A5 at 0x8000_0001, gnt held low 3 cycles → mem_req stable 4 cycles, mem_wmask=4'b0010, mem_wdata=0xA5A5_A5A5, mem_addr=0x8000_0000; resp_valid one cycle after gnt.
- sw at 0x8000_0002 (misaligned) and size=3 → resp_err=1, resp_rdata=0, mem_req never asserted, resp_valid 1 cycle after acceptance.
- TIMEOUT=4, lw with gnt but no rvalid → resp_err=1 after 4 REQ/WAIT cycles; a late rvalid in IDLE has no effect.
- rst pulled low while in WAIT → req_ready=1, mem_req=0, resp_valid=0 immediately; after release, a fresh lw completes normally.
